// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: shared SRAM widths, FSM encodings, base address and word-address helper
package sram_controller_pkg;
  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 16;
  localparam logic [31:0] SRAMC_BASE_ADDR = 32'd1024;
  typedef enum logic [1:0] {SRAMC_IDLE, SRAMC_LOW, SRAMC_HIGH, SRAMC_DONE} sramc_state_e;
  typedef logic [SRAM_ADDR_LEN-2:0] word_t;
  // Word index of a byte address relative to the SRAM window; bits 1:0 drop out.
  function automatic word_t sram_word(input logic [31:0] addr, input logic [31:0] base);
    return word_t'((addr - base) >> 2);
  endfunction
endpackage

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit MEM-stage accesses into two 16-bit SRAM accesses, stalling via ready
// Ports: clk; rst (async, active-low); rd_en/wr_en/addr/wdata request; rdata/ready to pipeline;
//        sram_we_en/sram_addr/sram_dq to the external 16-bit SRAM.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SRAMC_BASE_ADDR,
  parameter int          SETTLE    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     sram_we_en,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  inout  wire  [SRAM_DATA_LEN-1:0] sram_dq
);
  localparam int CW = $clog2(SETTLE + 1);
  sramc_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word_t word_q, word_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic wr_q, wr_d, we_q, we_d;
  logic [SRAM_ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_LEN-1:0] dq_q, dq_d;
  logic req, last, cap_lo, cap_hi;
  assign req    = rd_en | wr_en;
  assign last   = cnt_q == CW'(SETTLE - 1);
  assign cap_lo = state_q == SRAMC_LOW && last && !wr_q;
  assign cap_hi = state_q == SRAMC_HIGH && last && !wr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SRAMC_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      we_q        <= 1'b1;
      sram_addr_q <= '0;
      dq_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      sram_addr_q <= sram_addr_d;
      dq_q        <= dq_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    word_d  = word_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      SRAMC_IDLE: begin
        cnt_d = '0;
        if (req) begin
          state_d = SRAMC_LOW;
          word_d  = sram_word(addr, BASE_ADDR);
          wdata_d = wdata;
          wr_d    = wr_en;
        end
      end
      SRAMC_LOW: if (last) begin
        state_d = SRAMC_HIGH;
        cnt_d   = '0;
      end
      SRAMC_HIGH: if (last) begin
        state_d = SRAMC_DONE;
        cnt_d   = '0;
      end
      default: begin
        state_d = SRAMC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // SRAM pins are registered, so they are derived from the state being entered.
  always_comb begin
    we_d        = !(wr_d && (state_d == SRAMC_LOW || state_d == SRAMC_HIGH));
    sram_addr_d = state_d == SRAMC_LOW  ? {word_d, 1'b0} :
                  state_d == SRAMC_HIGH ? {word_d, 1'b1} : sram_addr_q;
    dq_d        = state_d == SRAMC_HIGH ? wdata_d[31:16] : wdata_d[15:0];
    rdata_d     = {cap_hi ? sram_dq : rdata_q[31:16], cap_lo ? sram_dq : rdata_q[15:0]};
    ready       = state_q == SRAMC_DONE || (state_q == SRAMC_IDLE && !req);
  end
  assign sram_dq    = we_q ? {SRAM_DATA_LEN{1'bz}} : dq_q;
  assign rdata      = rdata_q;
  assign sram_we_en = we_q;
  assign sram_addr  = sram_addr_q;
endmodule
